// File: rtl/avalon_st_policer.sv
// rtl/avalon_st_policer.sv - Avalon-ST policer: SOP/EOP framing, empty masking, truncation, violation counters.
module avalon_st_policer #(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int MAX_BEATS           = 64,
    parameter int SOP_MODE            = 0,
    parameter int CNT_WIDTH           = 16,
    localparam int DW = DATA_WIDTH_IN_BYTES * 8,
    localparam int EW = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DW-1:0]        untrusted_msg_data,
    input  logic                 untrusted_msg_valid,
    output logic                 untrusted_msg_rdy,
    input  logic                 untrusted_msg_sop,
    input  logic                 untrusted_msg_eop,
    input  logic [EW-1:0]        untrusted_msg_empty,
    output logic [DW-1:0]        enforced_msg_data,
    output logic                 enforced_msg_valid,
    input  logic                 enforced_msg_rdy,
    output logic                 enforced_msg_sop,
    output logic                 enforced_msg_eop,
    output logic [EW-1:0]        enforced_msg_empty,
    output logic                 missing_sop,
    output logic                 unexpected_sop,
    output logic                 truncated,
    output logic [CNT_WIDTH-1:0] missing_sop_cnt,
    output logic [CNT_WIDTH-1:0] unexpected_sop_cnt,
    output logic [CNT_WIDTH-1:0] truncated_cnt
);

    localparam int BW = $clog2(MAX_BEATS + 1);

    typedef enum logic [1:0] {BETWEEN_MSG, IN_MSG, FILLER, DISCARD} state_t;

    state_t          state, state_n;
    logic [BW-1:0]   beat_cnt, beat_cnt_n;
    logic [DW-1:0]   held_data;
    logic            held_eop;
    logic [EW-1:0]   held_empty;

    logic            can_load, accept, hold_ld;
    logic            ld, ld_sop, ld_eop;
    logic [DW-1:0]   ld_data, ld_data_masked;
    logic [EW-1:0]   ld_empty, in_empty_c;
    logic            ms_n, us_n, tr_n;

    function automatic logic [DW-1:0] mask_lanes(input logic [DW-1:0] d, input logic [EW-1:0] e);
        mask_lanes = d;
        for (int i = 0; i < DATA_WIDTH_IN_BYTES; i++) begin
            if (i < int'(e)) mask_lanes[8*i +: 8] = 8'h00;
        end
    endfunction

    assign can_load   = !enforced_msg_valid || enforced_msg_rdy;
    assign accept     = untrusted_msg_valid && untrusted_msg_rdy;
    assign in_empty_c = (int'(untrusted_msg_empty) >= DATA_WIDTH_IN_BYTES) ?
                        EW'(DATA_WIDTH_IN_BYTES - 1) : untrusted_msg_empty;

    always_comb begin
        untrusted_msg_rdy = 1'b0;
        case (state)
            BETWEEN_MSG, IN_MSG: untrusted_msg_rdy = can_load;
            FILLER:              untrusted_msg_rdy = 1'b0;
            DISCARD:             untrusted_msg_rdy = 1'b1;
            default:             untrusted_msg_rdy = 1'b0;
        endcase
    end

    always_comb begin
        state_n    = state;
        beat_cnt_n = beat_cnt;
        ld         = 1'b0;
        ld_data    = untrusted_msg_data;
        ld_sop     = 1'b0;
        ld_eop     = 1'b0;
        ld_empty   = '0;
        hold_ld    = 1'b0;
        ms_n       = 1'b0;
        us_n       = 1'b0;
        tr_n       = 1'b0;
        case (state)
            BETWEEN_MSG: begin
                if (accept) begin
                    if (untrusted_msg_sop) begin
                        ld         = 1'b1;
                        ld_sop     = 1'b1;
                        beat_cnt_n = BW'(1);
                        if (untrusted_msg_eop) begin
                            ld_eop   = 1'b1;
                            ld_empty = in_empty_c;
                        end else if (MAX_BEATS == 1) begin
                            ld_eop  = 1'b1;
                            tr_n    = 1'b1;
                            state_n = DISCARD;
                        end else begin
                            state_n = IN_MSG;
                        end
                    end else begin
                        ms_n = 1'b1;
                    end
                end
            end
            IN_MSG: begin
                if (accept) begin
                    us_n = untrusted_msg_sop;
                    if (untrusted_msg_sop && SOP_MODE == 1) begin
                        // Close the open message with a filler EOP; the SOP beat waits in the hold register.
                        ld         = 1'b1;
                        ld_data    = '0;
                        ld_eop     = 1'b1;
                        hold_ld    = 1'b1;
                        beat_cnt_n = '0;
                        state_n    = FILLER;
                    end else begin
                        ld         = 1'b1;
                        beat_cnt_n = beat_cnt + BW'(1);
                        if (untrusted_msg_eop) begin
                            ld_eop   = 1'b1;
                            ld_empty = in_empty_c;
                            state_n  = BETWEEN_MSG;
                        end else if (int'(beat_cnt) + 1 == MAX_BEATS) begin
                            ld_eop  = 1'b1;
                            tr_n    = 1'b1;
                            state_n = DISCARD;
                        end
                    end
                end
            end
            FILLER: begin
                if (can_load) begin
                    ld         = 1'b1;
                    ld_data    = held_data;
                    ld_sop     = 1'b1;
                    ld_eop     = held_eop;
                    ld_empty   = held_empty;
                    beat_cnt_n = BW'(1);
                    if (held_eop) begin
                        state_n = BETWEEN_MSG;
                    end else if (MAX_BEATS == 1) begin
                        ld_eop  = 1'b1;
                        tr_n    = 1'b1;
                        state_n = DISCARD;
                    end else begin
                        state_n = IN_MSG;
                    end
                end
            end
            DISCARD: begin
                if (accept && untrusted_msg_eop) state_n = BETWEEN_MSG;
            end
            default: state_n = BETWEEN_MSG;
        endcase
    end

    assign ld_data_masked = ld_eop ? mask_lanes(ld_data, ld_empty) : ld_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= BETWEEN_MSG;
            beat_cnt           <= '0;
            held_data          <= '0;
            held_eop           <= 1'b0;
            held_empty         <= '0;
            enforced_msg_valid <= 1'b0;
            enforced_msg_data  <= '0;
            enforced_msg_sop   <= 1'b0;
            enforced_msg_eop   <= 1'b0;
            enforced_msg_empty <= '0;
        end else begin
            state    <= state_n;
            beat_cnt <= beat_cnt_n;
            if (hold_ld) begin
                held_data  <= untrusted_msg_data;
                held_eop   <= untrusted_msg_eop;
                held_empty <= untrusted_msg_eop ? in_empty_c : '0;
            end
            if (can_load) begin
                enforced_msg_valid <= ld;
                if (ld) begin
                    enforced_msg_data  <= ld_data_masked;
                    enforced_msg_sop   <= ld_sop;
                    enforced_msg_eop   <= ld_eop;
                    enforced_msg_empty <= ld_empty;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            missing_sop        <= 1'b0;
            unexpected_sop     <= 1'b0;
            truncated          <= 1'b0;
            missing_sop_cnt    <= '0;
            unexpected_sop_cnt <= '0;
            truncated_cnt      <= '0;
        end else begin
            missing_sop    <= ms_n;
            unexpected_sop <= us_n;
            truncated      <= tr_n;
            if (ms_n && missing_sop_cnt != '1)    missing_sop_cnt    <= missing_sop_cnt + 1'b1;
            if (us_n && unexpected_sop_cnt != '1) unexpected_sop_cnt <= unexpected_sop_cnt + 1'b1;
            if (tr_n && truncated_cnt != '1)      truncated_cnt      <= truncated_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_avalon_st_policer.sv
// tb/tb_avalon_st_policer.sv - Bench for avalon_st_policer: STRIP and RESTART instances against a message-level model.
module tb_avalon_st_policer;

    localparam int MAXB = 4;
    typedef logic [133:0] beat_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] in_data [2];
    logic         in_valid [2];
    logic         in_rdy [2];
    logic         in_sop [2];
    logic         in_eop [2];
    logic [3:0]   in_empty [2];
    logic [127:0] out_data [2];
    logic         out_valid [2];
    logic         out_rdy [2];
    logic         out_sop [2];
    logic         out_eop [2];
    logic [3:0]   out_empty [2];
    logic         p_ms [2];
    logic         p_us [2];
    logic         p_tr [2];
    logic [15:0]  c_ms [2];
    logic [15:0]  c_us [2];
    logic [15:0]  c_tr [2];

    int checks = 0;
    int errors = 0;
    int bp [2];
    int m_mode [2];
    int m_n [2];
    int m_ms [2];
    int m_us [2];
    int m_tr [2];
    int seen_ms [2];
    int seen_us [2];
    int seen_tr [2];
    beat_t exp_q [2][$];
    beat_t got_q [2][$];
    beat_t prev_out [2];
    logic  stall_prev [2];
    int    last_n;
    beat_t last_beat;

    always #5 clk = ~clk;

    avalon_st_policer #(.DATA_WIDTH_IN_BYTES(16), .MAX_BEATS(MAXB), .SOP_MODE(0), .CNT_WIDTH(16)) dut_strip (
        .clk(clk), .rst(rst),
        .untrusted_msg_data(in_data[0]), .untrusted_msg_valid(in_valid[0]), .untrusted_msg_rdy(in_rdy[0]),
        .untrusted_msg_sop(in_sop[0]), .untrusted_msg_eop(in_eop[0]), .untrusted_msg_empty(in_empty[0]),
        .enforced_msg_data(out_data[0]), .enforced_msg_valid(out_valid[0]), .enforced_msg_rdy(out_rdy[0]),
        .enforced_msg_sop(out_sop[0]), .enforced_msg_eop(out_eop[0]), .enforced_msg_empty(out_empty[0]),
        .missing_sop(p_ms[0]), .unexpected_sop(p_us[0]), .truncated(p_tr[0]),
        .missing_sop_cnt(c_ms[0]), .unexpected_sop_cnt(c_us[0]), .truncated_cnt(c_tr[0]));

    avalon_st_policer #(.DATA_WIDTH_IN_BYTES(16), .MAX_BEATS(MAXB), .SOP_MODE(1), .CNT_WIDTH(16)) dut_restart (
        .clk(clk), .rst(rst),
        .untrusted_msg_data(in_data[1]), .untrusted_msg_valid(in_valid[1]), .untrusted_msg_rdy(in_rdy[1]),
        .untrusted_msg_sop(in_sop[1]), .untrusted_msg_eop(in_eop[1]), .untrusted_msg_empty(in_empty[1]),
        .enforced_msg_data(out_data[1]), .enforced_msg_valid(out_valid[1]), .enforced_msg_rdy(out_rdy[1]),
        .enforced_msg_sop(out_sop[1]), .enforced_msg_eop(out_eop[1]), .enforced_msg_empty(out_empty[1]),
        .missing_sop(p_ms[1]), .unexpected_sop(p_us[1]), .truncated(p_tr[1]),
        .missing_sop_cnt(c_ms[1]), .unexpected_sop_cnt(c_us[1]), .truncated_cnt(c_tr[1]));

    function automatic beat_t pk(input logic [127:0] d, input logic s, input logic e, input logic [3:0] em);
        return {s, e, em, d};
    endfunction

    task automatic chk(input string tag, input beat_t obs, input beat_t expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference output beat: lanes below empty are zero on EOP beats.
    task automatic m_emit(input int u, input logic [127:0] d, input logic s, input logic e, input logic [3:0] em);
        logic [127:0] md = d;
        if (e) for (int i = 0; i < int'(em); i++) md[8*i +: 8] = 8'h00;
        exp_q[u].push_back(pk(md, s, e, e ? em : 4'd0));
    endtask

    task automatic m_start(input int u, input logic [127:0] d, input logic e, input logic [3:0] em);
        m_n[u] = 1;
        if (e) begin m_emit(u, d, 1'b1, 1'b1, em); m_mode[u] = 0; end
        else if (m_n[u] == MAXB) begin m_emit(u, d, 1'b1, 1'b1, 4'd0); m_tr[u]++; m_mode[u] = 2; end
        else begin m_emit(u, d, 1'b1, 1'b0, 4'd0); m_mode[u] = 1; end
    endtask

    task automatic m_cont(input int u, input logic [127:0] d, input logic e, input logic [3:0] em);
        m_n[u]++;
        if (e) begin m_emit(u, d, 1'b0, 1'b1, em); m_mode[u] = 0; end
        else if (m_n[u] == MAXB) begin m_emit(u, d, 1'b0, 1'b1, 4'd0); m_tr[u]++; m_mode[u] = 2; end
        else m_emit(u, d, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic m_beat(input int u, input logic [127:0] d, input logic s, input logic e, input logic [3:0] em);
        if (m_mode[u] == 0) begin
            if (s) m_start(u, d, e, em); else m_ms[u]++;
        end else if (m_mode[u] == 1) begin
            if (s) begin
                m_us[u]++;
                if (u == 1) begin m_emit(u, '0, 1'b0, 1'b1, 4'd0); m_start(u, d, e, em); end
                else m_cont(u, d, e, em);
            end else m_cont(u, d, e, em);
        end else if (e) begin
            m_mode[u] = 0;
        end
    endtask

    task automatic send(input int u, input logic [127:0] d, input logic s, input logic e, input logic [3:0] em);
        int t = 0;
        logic done = 1'b0;
        m_beat(u, d, s, e, em);
        in_data[u] = d; in_sop[u] = s; in_eop[u] = e; in_empty[u] = em; in_valid[u] = 1'b1;
        while (!done && t < 200) begin
            @(negedge clk);
            t++;
            if (in_rdy[u]) done = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid[u] = 1'b0;
        chk("accept_timeout", beat_t'(done), beat_t'(1));
    endtask

    task automatic drain_check(input int u, input string tag);
        int t = 0;
        while (t < 400 && (got_q[u].size() < exp_q[u].size() || out_valid[u])) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk); #1;
        chk({tag, "_count"}, beat_t'(got_q[u].size()), beat_t'(exp_q[u].size()));
        for (int i = 0; i < exp_q[u].size() && i < got_q[u].size(); i++)
            chk({tag, "_beat"}, got_q[u][i], exp_q[u][i]);
        last_n = got_q[u].size();
        last_beat = (last_n > 0) ? got_q[u][last_n-1] : '0;
        got_q[u].delete();
        exp_q[u].delete();
    endtask

    task automatic check_cnts(input int u);
        chk("missing_sop_cnt", beat_t'(c_ms[u]), beat_t'(m_ms[u]));
        chk("unexpected_sop_cnt", beat_t'(c_us[u]), beat_t'(m_us[u]));
        chk("truncated_cnt", beat_t'(c_tr[u]), beat_t'(m_tr[u]));
        chk("missing_sop_pulses", beat_t'(seen_ms[u]), beat_t'(m_ms[u]));
        chk("unexpected_sop_pulses", beat_t'(seen_us[u]), beat_t'(m_us[u]));
        chk("truncated_pulses", beat_t'(seen_tr[u]), beat_t'(m_tr[u]));
    endtask

    task automatic rnd_msg(input int u);
        int len = $urandom_range(1, 6);
        if ($urandom_range(0, 7) == 0)
            send(u, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        for (int b = 0; b < len; b++)
            send(u, {$urandom, $urandom, $urandom, $urandom},
                 (b == 0) || ($urandom_range(0, 9) == 0), b == len - 1, 4'($urandom_range(0, 15)));
    endtask

    // Output monitor: collects handshaken beats, counts pulses, checks hold-while-stalled.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (rst) begin
                stall_prev[u] = 1'b0;
            end else begin
                if (stall_prev[u] && out_valid[u])
                    chk("hold_stable", pk(out_data[u], out_sop[u], out_eop[u], out_empty[u]), prev_out[u]);
                if (out_valid[u] && out_rdy[u])
                    got_q[u].push_back(pk(out_data[u], out_sop[u], out_eop[u], out_empty[u]));
                seen_ms[u] += int'(p_ms[u]);
                seen_us[u] += int'(p_us[u]);
                seen_tr[u] += int'(p_tr[u]);
                stall_prev[u] = out_valid[u] && !out_rdy[u];
                prev_out[u] = pk(out_data[u], out_sop[u], out_eop[u], out_empty[u]);
            end
        end
    end

    initial begin
        for (int u = 0; u < 2; u++) out_rdy[u] = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int u = 0; u < 2; u++)
                out_rdy[u] = (bp[u] == 0) ? 1'b1 : (bp[u] == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    initial begin
        logic [127:0] d0;
        for (int u = 0; u < 2; u++) begin
            in_data[u] = '0; in_valid[u] = 1'b0; in_sop[u] = 1'b0; in_eop[u] = 1'b0; in_empty[u] = '0;
            bp[u] = 0; m_mode[u] = 0; m_n[u] = 0; m_ms[u] = 0; m_us[u] = 0; m_tr[u] = 0;
            seen_ms[u] = 0; seen_us[u] = 0; seen_tr[u] = 0; stall_prev[u] = 1'b0; prev_out[u] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("reset_valid", beat_t'(out_valid[u]), beat_t'(0));
            chk("reset_in_rdy", beat_t'(in_rdy[u]), beat_t'(1));
            chk("reset_cnts", beat_t'({c_ms[u], c_us[u], c_tr[u]}), beat_t'(0));
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // 3-beat message, empty=5 on EOP, one-cycle latency
        d0 = {$urandom, $urandom, $urandom, $urandom};
        send(0, d0, 1'b1, 1'b0, 4'd0);
        chk("latency_valid", beat_t'(out_valid[0]), beat_t'(1));
        chk("latency_beat", pk(out_data[0], out_sop[0], out_eop[0], out_empty[0]), pk(d0, 1'b1, 1'b0, 4'd0));
        send(0, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, 4'd0);
        send(0, {128{1'b1}}, 1'b0, 1'b1, 4'd5);
        drain_check(0, "three_beat");
        chk("three_beat_tail", last_beat, pk({{88{1'b1}}, 40'h0}, 1'b0, 1'b1, 4'd5));
        check_cnts(0);

        // Two SOP-less beats then a 2-beat message
        send(0, {4{32'h1111_1111}}, 1'b0, 1'b0, 4'd0);
        send(0, {4{32'h2222_2222}}, 1'b0, 1'b1, 4'd3);
        send(0, {4{32'h3333_3333}}, 1'b1, 1'b0, 4'd0);
        send(0, {4{32'h4444_4444}}, 1'b0, 1'b1, 4'd2);
        drain_check(0, "missing_sop");
        chk("missing_sop_abs", beat_t'(c_ms[0]), beat_t'(2));
        check_cnts(0);

        // 7-beat message truncated to MAX_BEATS, then a normal message
        for (int b = 0; b < 7; b++)
            send(0, {$urandom, $urandom, $urandom, $urandom}, b == 0, b == 6, 4'd7);
        drain_check(0, "truncate");
        chk("truncate_len", beat_t'(last_n), beat_t'(4));
        chk("truncate_abs", beat_t'(c_tr[0]), beat_t'(1));
        send(0, {4{32'hcafe_f00d}}, 1'b1, 1'b0, 4'd0);
        send(0, {4{32'hdead_beef}}, 1'b0, 1'b1, 4'd1);
        drain_check(0, "after_truncate");

        // SOP on beat 3: STRIP continues, RESTART inserts a filler
        for (int u = 0; u < 2; u++) begin
            for (int b = 0; b < 4; b++)
                send(u, {$urandom, $urandom, $urandom, $urandom}, b == 0 || b == 2, b == 3, 4'd4);
            drain_check(u, u == 0 ? "strip" : "restart");
            chk("midsop_len", beat_t'(last_n), beat_t'(u == 0 ? 4 : 5));
            chk("unexpected_abs", beat_t'(c_us[u]), beat_t'(1));
            check_cnts(u);
        end

        // Random messages under 50% output backpressure
        for (int u = 0; u < 2; u++) begin
            bp[u] = 1;
            for (int m = 0; m < 1000; m++) rnd_msg(u);
            drain_check(u, "random");
            bp[u] = 0;
            check_cnts(u);
        end

        // Asynchronous reset mid-message with the output stalled
        bp[0] = 2;
        send(0, {4{32'h5a5a_5a5a}}, 1'b1, 1'b0, 4'd0);
        chk("stalled_valid", beat_t'(out_valid[0]), beat_t'(1));
        #2 rst = 1'b1;
        #1;
        for (int u = 0; u < 2; u++) begin
            chk("rst_outputs", pk(out_data[u], out_sop[u], out_eop[u], out_empty[u]), '0);
            chk("rst_valid", beat_t'(out_valid[u]), beat_t'(0));
            chk("rst_cnts", beat_t'({c_ms[u], c_us[u], c_tr[u], p_ms[u], p_us[u], p_tr[u]}), beat_t'(0));
            got_q[u].delete(); exp_q[u].delete();
            m_mode[u] = 0; m_n[u] = 0; m_ms[u] = 0; m_us[u] = 0; m_tr[u] = 0;
            seen_ms[u] = 0; seen_us[u] = 0; seen_tr[u] = 0;
        end
        bp[0] = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        send(0, {4{32'h7777_7777}}, 1'b0, 1'b0, 4'd0);
        send(0, {4{32'h8888_8888}}, 1'b0, 1'b1, 4'd0);
        drain_check(0, "post_reset");
        chk("post_reset_ms", beat_t'(c_ms[0]), beat_t'(2));
        check_cnts(0);
        check_cnts(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
